// File: rtl/div_if.sv
// div_if: request/response bundle between the pipeline and the iterative divider.
interface div_if;
   logic        start;
   logic        flush;
   logic [1:0]  divop;
   logic [31:0] operand1;
   logic [31:0] operand2;
   logic        busy;
   logic        done;
   logic [31:0] divout;
   modport master (output start, flush, divop, operand1, operand2, input busy, done, divout);
   modport slave  (input start, flush, divop, operand1, operand2, output busy, done, divout);
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-cycle restoring divider with RISC-V M-extension DIV/DIVU/REM/REMU semantics.
module div_unit (
   input logic clk,
   input logic rst,
   div_if.slave d
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_n;
   logic [4:0]  cnt;
   logic [32:0] rem, dvs, rem_n;
   logic [31:0] quo, quo_n, mag_a, spec_val, res;
   logic [33:0] shifted;
   logic        rem_op, neg_q, neg_r, sgn, neg_a, neg_b, dz, ovf, special, accept, fits;
   always_comb begin
      sgn      = ~d.divop[0];
      neg_a    = sgn & d.operand1[31];
      neg_b    = sgn & d.operand2[31];
      mag_a    = neg_a ? 32'd0 - d.operand1 : d.operand1;
      dz       = d.operand2 == 32'd0;
      ovf      = sgn && d.operand1 == 32'h8000_0000 && d.operand2 == 32'hffff_ffff;
      special  = dz | ovf;
      spec_val = dz ? (d.divop[1] ? d.operand1 : 32'hffff_ffff) : (d.divop[1] ? 32'd0 : 32'h8000_0000);
      accept   = state == IDLE && d.start && !d.flush;
      // One restoring step: shift the next dividend bit in, keep the difference if it fits.
      shifted  = {rem, quo[31]};
      fits     = shifted >= {1'b0, dvs};
      rem_n    = 33'(fits ? shifted - {1'b0, dvs} : shifted);
      quo_n    = {quo[30:0], fits};
      res      = rem_op ? 32'(neg_r ? 33'd0 - rem_n : rem_n) : (neg_q ? 32'd0 - quo_n : quo_n);
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= state_n;
   always_comb begin
      state_n = d.flush ? IDLE :
                state == IDLE ? (d.start ? (special ? DONE : CALC) : IDLE) :
                state == CALC ? (cnt == 5'd31 ? DONE : CALC) : IDLE;
   end
   always_comb begin
      d.busy = state == CALC;
      d.done = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         rem_op   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         d.divout <= '0;
      end else if (accept) begin
         cnt    <= '0;
         rem    <= '0;
         quo    <= mag_a;
         dvs    <= {1'b0, neg_b ? 32'd0 - d.operand2 : d.operand2};
         rem_op <= d.divop[1];
         neg_q  <= neg_a ^ neg_b;
         neg_r  <= neg_a;
         if (special) d.divout <= spec_val;
      end else if (state == CALC && !d.flush) begin
         cnt <= cnt + 5'd1;
         rem <= rem_n;
         quo <= quo_n;
         if (cnt == 5'd31) d.divout <= res;
      end
   end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock domain; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 flush  input  1  abort in-flight operation (pipeline flush).
REQ-006 DivOp  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 Operand1  input  32  dividend, captured when start is accepted.
REQ-008 Operand2  input  32  divisor, captured when start is accepted.
REQ-009 busy  output  1  high while an operation is accepted and not yet completed; drives the pipeline stall.
REQ-010 done  output  1  one-cycle pulse when DivOut is valid.
REQ-011 DivOut  output  32  result; holds the last value until the next accepted start.

Function
REQ-012 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-013 start is accepted only when state=IDLE, flush=0 and rst=0; Operand1, Operand2 and DivOp are latched on the accepting edge; start in any other state SHALL be ignored.
REQ-014 Normal accept: IDLE->CALC; CALC runs exactly 32 restoring shift-subtract iterations of one bit per cycle; CALC->DONE after the 32nd iteration; DONE->IDLE after one cycle.
REQ-015 Latency: for a start accepted at edge N, done=1 during cycle N+33 and busy=1 during cycles N+1 through N+32 inclusive; busy=0 while done=1.
REQ-016 Signed ops (DIV, REM) SHALL divide magnitudes. The quotient is negated when the operand signs differ. The remainder takes the sign of the dividend. Magnitudes use a 33-bit working width so -2^31 is handled.
REQ-017 Divide by zero (Operand2=0) SHALL bypass CALC, going IDLE->DONE; DIV and DIVU return 0xFFFFFFFF; REM and REMU return Operand1; done asserts in cycle N+1.
REQ-018 Signed overflow (DIV or REM, Operand1=0x80000000, Operand2=0xFFFFFFFF) SHALL bypass CALC; DIV returns 0x80000000; REM returns 0x00000000; done asserts in cycle N+1.
REQ-019 Unsigned ops SHALL treat both operands as 32-bit unsigned; no sign fix-up.
REQ-020 flush=1 in CALC or DONE SHALL force IDLE at the next edge. In that case done is not asserted and DivOut is not updated. If done was already high that cycle, the pulse is not extended.
REQ-021 Simultaneous start and flush in IDLE: flush wins and the start is not accepted.
REQ-022 DivOut SHALL update only on the edge entering DONE and is stable otherwise.
REQ-023 No exceptions or traps SHALL be raised; the results follow RISC-V M-extension semantics exactly.
REQ-024 A new start is accepted in the IDLE cycle immediately after DONE, giving a back-to-back throughput of one op per 34 cycles.

Reset
REQ-025 rst=1 SHALL force state=IDLE, busy=0, done=0, DivOut=0x00000000, and clear the iteration counter and working registers at the next edge.
REQ-026 rst asserted mid-CALC SHALL abort the operation at that edge; no done is produced.
REQ-027 rst SHALL take priority over flush and start.

Verification
REQ-028 DIVU 100/7, start at edge N -> busy cycles N+1..N+32, done at N+33, DivOut=14; REMU 100/7 -> DivOut=2.
REQ-029 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> -3; REM 7/-2 -> 1.
REQ-030 DIV 5/0 -> done at N+1, DivOut=0xFFFFFFFF; REMU 5/0 -> DivOut=5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1; REM of the same operands -> 0.
REQ-031 flush at cycle N+10 of a CALC -> IDLE at N+11; no done pulse; DivOut retains the prior result; a new start at N+11 completes normally.
REQ-032 rst at cycle N+20 of a CALC -> at the next edge busy=0, done=0, DivOut=0; start during busy is ignored and the in-flight result is unchanged.
REQ-033 Random regression of 10k operand pairs over all four ops vs. a reference model, including 0, 1, -1, 0x80000000 and 0xFFFFFFFF corners -> all results match.
